// File: rtl/ex_muldiv.sv
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers,
//            stalling later HI/LO-family instructions while busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iStart,
    input  logic [5:0]  iFun,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oStall,
    output logic        oBusy,
    output logic [31:0] oResult,
    output logic [31:0] oHi,
    output logic [31:0] oLo
);

    localparam logic [5:0] c_FN_MFHI = 6'h10;
    localparam logic [5:0] c_FN_MTHI = 6'h11;
    localparam logic [5:0] c_FN_MFLO = 6'h12;
    localparam logic [5:0] c_FN_MTLO = 6'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic        r_div;
    logic        r_sa;
    logic        r_sb;
    logic        r_dz;
    logic [31:0] r_op;
    logic [31:0] r_dvd;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // 0x18..0x1B are long ops, 0x10..0x13 are HI/LO moves
    logic        w_is_long;
    logic        w_is_move;
    logic        w_signed;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign w_is_long = (iFun[5:2] == 4'b0110);
    assign w_is_move = (iFun[5:2] == 4'b0100);
    assign w_signed  = ~iFun[0];
    assign w_sa      = w_signed & iA[31];
    assign w_sb      = w_signed & iB[31];
    assign w_mag_a   = w_sa ? (32'd0 - iA) : iA;
    assign w_mag_b   = w_sb ? (32'd0 - iB) : iB;

    // Multiply step: low half of the accumulator holds the remaining multiplier bits
    logic [32:0] w_msum;
    logic [63:0] w_mul_next;

    assign w_msum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_op} : 33'd0);
    assign w_mul_next = {w_msum, r_acc[31:1]};

    // Restoring divide step: partial remainder in the high half, quotient shifts into the low half
    logic [32:0] w_rs;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_div_next;

    assign w_rs       = r_acc[63:31];
    assign w_ge       = (w_rs >= {1'b0, r_op});
    assign w_sub      = w_rs[31:0] - r_op;
    assign w_div_next = {(w_ge ? w_sub : w_rs[31:0]), r_acc[30:0], w_ge};

    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_prod = (r_sa ^ r_sb) ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = (r_sa ^ r_sb) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= 5'd0;
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_op    <= 32'd0;
            r_dvd   <= 32'd0;
            r_acc   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iStart && w_is_long) begin
                        r_state <= CALC;
                        r_count <= 5'd0;
                        r_div   <= iFun[1];
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_dz    <= (iB == 32'd0);
                        r_dvd   <= iA;
                        r_op    <= iFun[1] ? w_mag_b : w_mag_a;
                        r_acc   <= {32'd0, (iFun[1] ? w_mag_a : w_mag_b)};
                    end else if (iStart && iFun == c_FN_MTHI) begin
                        r_hi <= iA;
                    end else if (iStart && iFun == c_FN_MTLO) begin
                        r_lo <= iA;
                    end
                end
                CALC: begin
                    r_acc   <= r_div ? w_div_next : w_mul_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!r_div) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (r_dz) begin
                        r_hi <= r_dvd;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oBusy  = (r_state != IDLE);
    assign oStall = iStart & (w_is_long | w_is_move) & oBusy;
    assign oHi    = r_hi;
    assign oLo    = r_lo;

    always_comb begin
        oResult = 32'd0;
        if (iStart && !oBusy && iFun == c_FN_MFHI) begin
            oResult = r_hi;
        end else if (iStart && !oBusy && iFun == c_FN_MFLO) begin
            oResult = r_lo;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Directed self-checking bench for ex_muldiv.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic        iStart;
    logic [5:0]  iFun;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oStall;
    logic        oBusy;
    logic [31:0] oResult;
    logic [31:0] oHi;
    logic [31:0] oLo;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iStart  (iStart),
        .iFun    (iFun),
        .iA      (iA),
        .iB      (iB),
        .oStall  (oStall),
        .oBusy   (oBusy),
        .oResult (oResult),
        .oHi     (oHi),
        .oLo     (oLo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an op at a negedge; it is sampled at the next posedge (t0).
    // Afterwards counts negedges with oBusy high, ending one negedge after t33.
    task automatic run_long(input logic [5:0] fun, input logic [31:0] a,
                            input logic [31:0] b, output int busy);
        @(negedge clk);
        iStart = 1'b1; iFun = fun; iA = a; iB = b;
        #1;
        chk("long_start_nostall", {31'd0, oStall}, 32'd0);
        @(negedge clk);
        iStart = 1'b0; iFun = 6'h00; iA = 32'd0; iB = 32'd0;
        busy = 0;
        while (oBusy === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
        end
    endtask

    int busy;
    int stalls;

    initial begin
        rst_n = 1'b0; iStart = 1'b0; iFun = 6'h00; iA = 32'd0; iB = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_stall",  {31'd0, oStall}, 32'd0);
        chk("rst_busy",   {31'd0, oBusy},  32'd0);
        chk("rst_result", oResult, 32'd0);
        chk("rst_hi",     oHi, 32'd0);
        chk("rst_lo",     oLo, 32'd0);
        rst_n = 1'b1;

        // MULT -3 * 5
        run_long(6'h18, 32'hFFFF_FFFD, 32'd5, busy);
        chk("mult_busy_cycles", busy, 32'd33);
        chk("mult_hi", oHi, 32'hFFFF_FFFF);
        chk("mult_lo", oLo, 32'hFFFF_FFF1);

        // MULTU max * max
        run_long(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy);
        chk("multu_busy_cycles", busy, 32'd33);
        chk("multu_hi", oHi, 32'hFFFF_FFFE);
        chk("multu_lo", oLo, 32'h0000_0001);

        // DIV -7 / 2
        run_long(6'h1A, 32'hFFFF_FFF9, 32'd2, busy);
        chk("div_hi", oHi, 32'hFFFF_FFFF);
        chk("div_lo", oLo, 32'hFFFF_FFFD);

        // DIVU by zero
        run_long(6'h1B, 32'h1234_5678, 32'd0, busy);
        chk("divz_busy_cycles", busy, 32'd33);
        chk("divz_hi", oHi, 32'h1234_5678);
        chk("divz_lo", oLo, 32'hFFFF_FFFF);

        // DIV most-negative / -1
        run_long(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, busy);
        chk("divovf_hi", oHi, 32'h0000_0000);
        chk("divovf_lo", oLo, 32'h8000_0000);

        // MULT 6*7 followed immediately by a stalled MFLO
        @(negedge clk);
        iStart = 1'b1; iFun = 6'h18; iA = 32'd6; iB = 32'd7;
        @(negedge clk);
        iFun = 6'h12; iA = 32'd0; iB = 32'd0;
        stalls = 0;
        #1;
        while (oStall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk("mflo_stall_cycles", stalls, 32'd33);
        chk("mflo_after_stall", oResult, 32'h0000_002A);
        chk("mflo_busy_clear", {31'd0, oBusy}, 32'd0);
        @(negedge clk);
        iStart = 1'b0; iFun = 6'h00;

        // Independent ADD during a busy window is not stalled
        @(negedge clk);
        iStart = 1'b1; iFun = 6'h19; iA = 32'd3; iB = 32'd4;
        @(negedge clk);
        iFun = 6'h20;
        #1;
        chk("add_busy", {31'd0, oBusy}, 32'd1);
        chk("add_nostall", {31'd0, oStall}, 32'd0);
        chk("add_result", oResult, 32'd0);
        @(negedge clk);
        iStart = 1'b0; iFun = 6'h00;
        repeat (40) @(negedge clk);
        chk("multu_small_lo", oLo, 32'd12);

        // MTHI then MFHI
        iStart = 1'b1; iFun = 6'h11; iA = 32'hCAFE_BABE;
        #1;
        chk("mthi_nostall", {31'd0, oStall}, 32'd0);
        @(negedge clk);
        iFun = 6'h10; iA = 32'd0;
        #1;
        chk("mfhi_nostall", {31'd0, oStall}, 32'd0);
        chk("mfhi_result", oResult, 32'hCAFE_BABE);
        chk("mthi_lo_untouched", oLo, 32'd12);

        // DIV aborted by reset mid-iteration
        @(negedge clk);
        iStart = 1'b1; iFun = 6'h1A; iA = 32'd100; iB = 32'd7;
        @(negedge clk);
        iStart = 1'b0; iFun = 6'h00;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", {31'd0, oBusy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, oBusy}, 32'd0);
        chk("abort_hi", oHi, 32'd0);
        chk("abort_lo", oLo, 32'd0);
        iStart = 1'b1; iFun = 6'h12;
        #1;
        chk("abort_mflo_nostall", {31'd0, oStall}, 32'd0);
        chk("abort_mflo_result", oResult, 32'd0);
        @(negedge clk);
        iStart = 1'b0; iFun = 6'h00;
        repeat (40) @(negedge clk);
        chk("abort_no_late_write", oLo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 32-bit integer multiply/divide unit with HI/LO registers, in the EX stage directly downstream of the ID/EX pipeline register. It executes MULT/MULTU/DIV/DIVU in 33 cycles and MTHI/MTLO/MFHI/MFLO in one. It drives the stall input of ID/EX and the upstream stages so that any later HI/LO-family instruction waits until the result is committed. Independent instructions continue to flow while an operation is in flight.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- iStart  in  1  ID/EX holds a valid (non-bubble) R-type instruction this cycle.
- iFun  in  6  funct field from ID/EX.
- iA  in  32  rs operand (ID/EX RegOut1).
- iB  in  32  rt operand (ID/EX RegOut2).
- oStall  out  1  hold ID/EX and upstream stages this cycle.
- oBusy  out  1  multiply/divide in flight (state != IDLE).
- oResult  out  32  HI for MFHI, LO for MFLO, otherwise 0.
- oHi, oLo  out  32 each  architectural HI/LO registers.

## Operation
- Funct codes:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU (long ops).
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
  - These eight codes are the "HI/LO family".
  - Any other funct is ignored.
- FSM states IDLE, CALC, FIX.
  - IDLE, iStart and long op: latch |iA|, |iB|, sign flags and op type; clear count; go to CALC. For MULTU/DIVU the operands are taken unsigned, with sign flags 0.
  - CALC: perform one iteration per cycle.
    - Multiply: shift-add on a 64-bit accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - Count increments; after the 32nd iteration (count 31), go to FIX.
  - FIX: apply signs and write HI/LO; go to IDLE.
- Sign rules:
  - Product is negated (64-bit two's complement) if sA^sB.
  - Quotient is negated if sA^sB; remainder takes the sign of sA.
  - Multiply result: HI=product[63:32], LO=product[31:0].
  - Divide result: LO=quotient, HI=remainder.
- Divide by zero (any divide with iB==0): HI=iA as latched (original dividend), LO=0xFFFFFFFF. No exception; latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of magnitude arithmetic with wrap.
- MTHI/MTLO in IDLE: HI or LO is loaded from iA at the edge. No stall.
- MFHI/MFLO in IDLE: oResult is combinational from current HI/LO.
- oStall = iStart & (iFun in HI/LO family) & (state != IDLE).
  - Non-family instructions are never stalled.
  - The starting long op itself is not stalled; it leaves EX and the unit works in the background.
- rst_n low at an edge: state IDLE, HI=LO=0, count=0, internal operands cleared. Any in-flight operation is aborted with no HI/LO write.

## Timing
- Reset values: oStall=0, oBusy=0, oResult=0, oHi=0, oLo=0.
- Long op sampled at edge t0. oBusy is high from after t0 through the FIX edge t33 (33 cycles). HI/LO hold new values from after t33.
- A family instruction presented the cycle after t0 sees oStall=1 for 33 cycles. It proceeds in the cycle after t33; MFHI there reads the new HI.
- A back-to-back long op behind a long op therefore starts at t33+1.
- MTHI/MTLO: one-cycle write, visible to MFHI/MFLO on the next cycle.
- oStall and oResult are combinational from iStart, iFun and registered state; there is no registered output latency.
- HI/LO change only at a FIX edge, at an MTHI/MTLO edge, or at reset.

## Test plan
- MULT iA=0xFFFFFFFD (-3), iB=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; oBusy high exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x12345678/0 -> HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 6x7, then MFLO held by stall:
  - oStall=1 for 33 cycles, then oResult=42 (0x2A).
  - An interleaved ADD (funct 0x20) during the busy window sees oStall=0.
- MTHI iA=0xCAFEBABE, next cycle MFHI -> oResult=0xCAFEBABE with no stall.
- DIV started, rst_n low at iteration 10 -> next cycle oBusy=0, HI=LO=0. A following MFLO returns 0 unstalled.
